// File: rtl/frame_minmax_tracker.sv
// Frame min/max tracker: scans FRAME_LEN unsigned 8-bit samples and reports
// the frame maximum and minimum with the index of the first occurrence of each.

// Unsigned 8-bit magnitude comparator: exactly one of lt/et/gt is high.
module comparator8 (
   input  logic [7:0] p,
   input  logic [7:0] q,
   output logic       lt,
   output logic       et,
   output logic       gt
);

   // Pure combinational relation of p against q.
   always_comb begin
      lt = (p <  q);
      et = (p == q);
      gt = (p >  q);
   end

endmodule

module frame_minmax_tracker #(
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned IDX_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [7:0]       max_out,
   output logic [7:0]       min_out,
   output logic [IDX_W-1:0] max_idx,
   output logic [IDX_W-1:0] min_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q,    state_d;
   logic [7:0]       max_q,      max_d;
   logic [7:0]       min_q,      min_d;
   logic [IDX_W-1:0] max_idx_q,  max_idx_d;
   logic [IDX_W-1:0] min_idx_q,  min_idx_d;
   logic [IDX_W-1:0] cnt_q,      cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;

   logic xfer_c;
   logic max_lt_c, max_et_c, max_gt_c;
   logic min_lt_c, min_et_c, min_gt_c;
   logic max_take_c, min_take_c;

   // Sample against running maximum.
   comparator8 u_cmp_max (
      .p  (in_data),
      .q  (max_q),
      .lt (max_lt_c),
      .et (max_et_c),
      .gt (max_gt_c)
   );

   // Sample against running minimum.
   comparator8 u_cmp_min (
      .p  (in_data),
      .q  (min_q),
      .lt (min_lt_c),
      .et (min_et_c),
      .gt (min_gt_c)
   );

   // Strictly-greater / strictly-less updates only, so ties keep the earliest index.
   always_comb begin
      xfer_c     = in_valid & in_ready_q;
      max_take_c = max_gt_c & ~max_et_c & ~max_lt_c;
      min_take_c = min_lt_c & ~min_et_c & ~min_gt_c;
   end

   // Next-state and datapath update; handshake/status flags follow the next state.
   always_comb begin
      state_d   = state_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
      cnt_d     = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (xfer_c) begin
               max_d     = in_data;
               min_d     = in_data;
               max_idx_d = '0;
               min_idx_d = '0;
               if (FRAME_LEN == 1) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = ONE_IDX;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (xfer_c) begin
               if (max_take_c) begin
                  max_d     = in_data;
                  max_idx_d = cnt_q;
               end
               if (min_take_c) begin
                  min_d     = in_data;
                  min_idx_d = cnt_q;
               end
               // Hold cnt on the final transfer so it never passes FRAME_LEN-1.
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + ONE_IDX;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d = (state_d == ST_FIRST) || (state_d == ST_RUN);
      busy_d     = (state_d == ST_FIRST) || (state_d == ST_RUN);
      done_d     = (state_d == ST_DONE);
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         max_q      <= 8'h00;
         min_q      <= 8'hFF;
         max_idx_q  <= '0;
         min_idx_q  <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         max_q      <= max_d;
         min_q      <= min_d;
         max_idx_q  <= max_idx_d;
         min_idx_q  <= min_idx_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign max_out  = max_q;
   assign min_out  = min_q;
   assign max_idx  = max_idx_q;
   assign min_idx  = min_idx_q;

endmodule
